mul_div_unit: RTL and testbench

- Iterative multiply/divide unit in the multicycle datapath, directly downstream of the register file.
- Consumes the two read-port operands (rs, rt) on a start pulse and computes MULT/MULTU/DIV/DIVU over 32 iterations.
- Holds results in internal HI/LO registers, which the control unit reads for MFHI/MFLO write-back.
- Also services MTHI/MTLO direct writes.

---
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: MULT/MULTU/DIV/DIVU over WIDTH cycles,
// results held in HI/LO, with MTHI/MTLO direct writes while idle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_MulDiv_start,
  input  logic [1:0]       i_MulDiv_op,
  input  logic [WIDTH-1:0] i_MulDiv_a,
  input  logic [WIDTH-1:0] i_MulDiv_b,
  input  logic             i_MulDiv_hi_we,
  input  logic             i_MulDiv_lo_we,
  input  logic [WIDTH-1:0] i_MulDiv_wdata,
  output logic             o_MulDiv_busy,
  output logic             o_MulDiv_done,
  output logic [WIDTH-1:0] o_MulDiv_hi,
  output logic [WIDTH-1:0] o_MulDiv_lo
);

  localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign accept    = i_MulDiv_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign signed_op = ~i_MulDiv_op[0];
  assign a_neg     = signed_op & i_MulDiv_a[WIDTH-1];
  assign b_neg     = signed_op & i_MulDiv_b[WIDTH-1];
  assign a_mag     = a_neg ? -i_MulDiv_a : i_MulDiv_a;
  assign b_mag     = b_neg ? -i_MulDiv_b : i_MulDiv_b;

  // Multiply: add B into the upper half when the LSB is set, then shift the
  // whole accumulator right, keeping the carry as the new top bit.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, b_mag_q} : '0);

  // Divide: accumulator holds {remainder, dividend/quotient}; shift one
  // dividend bit into the remainder and trial-subtract the divisor.
  assign div_part  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_part - {1'b0, b_mag_q};

  assign prod_fix = sign_q_q ? -acc_q : acc_q;
  assign quo      = sign_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem      = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    cnt_d    = cnt_q;
    b_mag_d  = b_mag_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          is_div_d = i_MulDiv_op[1];
          sign_q_d = a_neg ^ b_neg;
          sign_r_d = a_neg;
          b_mag_d  = b_mag;
          a_raw_d  = i_MulDiv_a;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          cnt_d    = '0;
          state_d  = S_CALC;
        end else begin
          if (i_MulDiv_hi_we) begin
            hi_d = i_MulDiv_wdata;
          end
          if (i_MulDiv_lo_we) begin
            lo_d = i_MulDiv_wdata;
          end
        end
      end

      S_CALC: begin
        if (!is_div_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
          acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_mag_q == '0) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      cnt_q    <= '0;
      b_mag_q  <= '0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      cnt_q    <= cnt_d;
      b_mag_q  <= b_mag_d;
      a_raw_q  <= a_raw_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign o_MulDiv_busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign o_MulDiv_done = (state_q == S_DONE);
  assign o_MulDiv_hi   = hi_q;
  assign o_MulDiv_lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO pushed on start, popped on done.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_MulDiv_start (start),
    .i_MulDiv_op    (op),
    .i_MulDiv_a     (a),
    .i_MulDiv_b     (b),
    .i_MulDiv_hi_we (hi_we),
    .i_MulDiv_lo_we (lo_we),
    .i_MulDiv_wdata (wdata),
    .o_MulDiv_busy  (busy),
    .o_MulDiv_done  (done),
    .o_MulDiv_hi    (hi),
    .o_MulDiv_lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is accepted at the following posedge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back({eh, el});
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
  endtask

  // Waits (bounded) for done; exp_cyc is the negedge index at which done is due.
  task automatic wait_done(input string tag, input int exp_cyc);
    int n = 0;
    int bc = 0;
    logic seen = 1'b0;
    logic [63:0] e;
    for (int i = 0; i < exp_cyc + 6; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(exp_cyc));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_cyc - 1));
    check({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu_max", 34);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done("mult_neg3x5", 34);
    @(negedge clk);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_neg7by2", 34);
    @(negedge clk);
    start_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    wait_done("div_7byneg2", 34);
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    wait_done("divu_by0", 34);
    @(negedge clk);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    wait_done("div_by0", 34);
    @(negedge clk);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    wait_done("div_ovf", 34);

    // Start and MTHI issued mid-CALC must both be ignored.
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd2;
    b     = 32'd3;
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    wait_done("divu_ignore", 29);

    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_lo", 64'(lo), 64'd14);
    lo_we = 1'b1;
    wdata = 32'hCAFE;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    @(negedge clk);
    check("mtlo_hi", 64'(hi), 64'h1234);
    check("mtlo_lo", 64'(lo), 64'hCAFE);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    check("mtboth_hi", 64'(hi), 64'h5555_AAAA);
    check("mtboth_lo", 64'(lo), 64'h5555_AAAA);

    // Asynchronous reset mid-CALC discards the operation.
    start_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12);
    repeat (9) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) check("arst_no_done", 64'(done), 64'd0);
    end
    check("arst_idle_busy", 64'(busy), 64'd0);

    start_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_done("multu_6x7", 34);
    // Back-to-back: new request issued during the done cycle.
    start_op(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);
    wait_done("divu_b2b", 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
